// File: rtl/spi_shifter_pkg.sv
// Shared definitions for the SPI serial datapath: maximum frame width,
// bit-order enumeration and a bit-reverse helper.
package spi_pkg;

    localparam int FRAME_MAX = 8;

    typedef enum logic {
        MSB_FIRST = 1'b0,
        LSB_FIRST = 1'b1
    } endian_t;

    // Mirror a FRAME_MAX-wide word end for end.
    function automatic logic [FRAME_MAX-1:0] bitrev(input logic [FRAME_MAX-1:0] d);
        logic [FRAME_MAX-1:0] r;
        for (int i = 0; i < FRAME_MAX; i++) begin
            r[i] = d[FRAME_MAX-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_shifter_if.sv
// FIFO-side bus of the SPI shifter: TX FIFO read port and RX FIFO write port.
// master = the shifter (pops TX, pushes RX); slave = the FIFO pair.
interface spi_shifter_if
    import spi_pkg::*;
#(
    parameter int FRAME_W = FRAME_MAX
);
    logic [FRAME_W-1:0] TxData;
    logic               txFIFOReadEmpty;
    logic               TxFIFORead;
    logic               rxFIFOWriteFull;
    logic               RxFIFOWrite;
    logic [FRAME_W-1:0] RxData;
    logic               RxDropped;

    modport master (
        input  TxData,
        input  txFIFOReadEmpty,
        input  rxFIFOWriteFull,
        output TxFIFORead,
        output RxFIFOWrite,
        output RxData,
        output RxDropped
    );

    modport slave (
        output TxData,
        output txFIFOReadEmpty,
        output rxFIFOWriteFull,
        input  TxFIFORead,
        input  RxFIFOWrite,
        input  RxData,
        input  RxDropped
    );
endinterface

// File: rtl/spi_shifter_align.sv
// spi_align: combinational frame aligner. Optionally bit-reverses the word,
// then shifts it left or right by a variable amount. Used once to left-align
// TX load data and once to right-align a received frame.
module spi_align
    import spi_pkg::*;
#(
    parameter int W  = FRAME_MAX,
    parameter int LW = $clog2(W + 1)
) (
    input  logic [W-1:0]  dataIn,
    input  logic          reverse,
    input  logic          shiftRight,
    input  logic [LW-1:0] shiftAmt,
    output logic [W-1:0]  dataOut
);
    logic [W-1:0] revData;
    logic [W-1:0] orderedData;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : gRev
            assign revData[gi] = dataIn[W-1-gi];
        end
    endgenerate

    assign orderedData = reverse ? revData : dataIn;
    assign dataOut     = shiftRight ? (orderedData >> shiftAmt) : (orderedData << shiftAmt);

endmodule

// File: rtl/spi_shifter.sv
// spi_shifter: SPI serial datapath. Loads TX FIFO words into a left-aligned
// transmit shift register advanced on ShiftEdge, samples the serial input on
// SampleEdge and pushes each completed, right-aligned frame into the RX FIFO.
// Optional build macro SPI_LOOPBACK_EN adds a Loopback input that samples
// SPIOut instead of SPIIn.
module spi_shifter
    import spi_pkg::*;
#(
    parameter int FRAME_W = FRAME_MAX
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       TransmitStart,
    input  logic       EndOfFrameDelay,
    input  logic       ShiftEdge,
    input  logic       SampleEdge,
    input  logic       Transmitting,
    input  logic [3:0] FrameLength,
    input  logic       Endian,
    input  logic       SPIIn,
`ifdef SPI_LOOPBACK_EN
    input  logic       Loopback,
`endif
    output logic       SPIOut,
    spi_shifter_if.master fifoBus
);
    localparam int LW = $clog2(FRAME_W + 1);

    logic [FRAME_W-1:0] txShiftReg;
    logic [FRAME_W-2:0] rxShiftReg;
    logic [LW-1:0]      sampleCntReg;
    logic [FRAME_W-1:0] rxDataReg;
    logic               framePendingReg;

    logic [LW-1:0]      frameLen;
    logic [LW-1:0]      padAmt;
    logic               lsbFirst;
    logic               txLoad;
    logic               sampleBit;
    logic               sampleFire;
    logic               frameDone;
    logic [FRAME_W-1:0] txAligned;
    logic [FRAME_W-1:0] rxFrame;
    logic [FRAME_W-1:0] rxAligned;
    logic [FRAME_W-1:0] rxMask;

    // Effective frame length: 0 or anything wider than the register means full width.
    always_comb begin
        frameLen = LW'(FRAME_W);
        if ((FrameLength != 4'd0) && (int'(FrameLength) <= FRAME_W)) begin
            frameLen = LW'(FrameLength);
        end
    end

    assign padAmt   = LW'(FRAME_W) - frameLen;
    assign lsbFirst = (endian_t'(Endian) == LSB_FIRST);
    assign txLoad   = TransmitStart | (EndOfFrameDelay & ~fifoBus.txFIFOReadEmpty);

`ifdef SPI_LOOPBACK_EN
    assign sampleBit = Loopback ? SPIOut : SPIIn;
`else
    assign sampleBit = SPIIn;
`endif

    // A sample coinciding with TransmitStart belongs to no frame and is dropped.
    assign sampleFire = SampleEdge & Transmitting & ~TransmitStart;
    assign frameDone  = sampleFire & ((sampleCntReg + LW'(1)) >= frameLen);
    assign rxFrame    = {rxShiftReg, sampleBit};
    assign rxMask     = ~({FRAME_W{1'b1}} << frameLen);

    // TX: MSB-first shifts the word up so its top valid bit leaves first;
    // LSB-first mirrors it so bit 0 leaves first.
    spi_align #(.W(FRAME_W), .LW(LW)) uTxAlign (
        .dataIn     (fifoBus.TxData),
        .reverse    (lsbFirst),
        .shiftRight (1'b0),
        .shiftAmt   (lsbFirst ? LW'(0) : padAmt),
        .dataOut    (txAligned)
    );

    // RX: MSB-first frame is already right-aligned; LSB-first is mirrored and
    // pulled back down by the unused width.
    spi_align #(.W(FRAME_W), .LW(LW)) uRxAlign (
        .dataIn     (rxFrame),
        .reverse    (lsbFirst),
        .shiftRight (1'b1),
        .shiftAmt   (lsbFirst ? padAmt : LW'(0)),
        .dataOut    (rxAligned)
    );

    // Transmit shift register: load has priority over shifting; idle states hold.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            txShiftReg <= '0;
        end else if (txLoad) begin
            txShiftReg <= txAligned;
        end else if (ShiftEdge & Transmitting) begin
            txShiftReg <= {txShiftReg[FRAME_W-2:0], 1'b0};
        end
    end

    // Receive shift register and bit counter; cleared on transfer start and frame completion.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rxShiftReg   <= '0;
            sampleCntReg <= '0;
        end else if (TransmitStart || frameDone) begin
            rxShiftReg   <= '0;
            sampleCntReg <= '0;
        end else if (sampleFire) begin
            rxShiftReg   <= rxFrame[FRAME_W-2:0];
            sampleCntReg <= sampleCntReg + LW'(1);
        end
    end

    // Capture the aligned frame and flag a push for the following cycle.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rxDataReg       <= '0;
            framePendingReg <= 1'b0;
        end else begin
            framePendingReg <= frameDone;
            if (frameDone) begin
                rxDataReg <= rxAligned & rxMask;
            end
        end
    end

    assign SPIOut              = txShiftReg[FRAME_W-1];
    assign fifoBus.TxFIFORead  = txLoad;
    assign fifoBus.RxFIFOWrite = framePendingReg & ~fifoBus.rxFIFOWriteFull;
    assign fifoBus.RxDropped   = framePendingReg & fifoBus.rxFIFOWriteFull;
    assign fifoBus.RxData      = rxDataReg;

endmodule

// File: tb/tb_spi_shifter.sv
// Testbench for spi_shifter: table of single-frame vectors plus hand-written
// multi-cycle sequences; received frames are checked against a queue of
// expected words. Build with SPI_LOOPBACK_EN to also exercise Loopback.
module tb_spi_shifter;
    import spi_pkg::*;

    logic       PCLK = 1'b0;
    logic       PRESETn;
    logic       TransmitStart, EndOfFrameDelay, ShiftEdge, SampleEdge, Transmitting;
    logic [3:0] FrameLength;
    logic       Endian;
    logic       SPIIn;
    logic       SPIOut;
    logic       loopSel, spiInDrv;
`ifdef SPI_LOOPBACK_EN
    logic       Loopback;
`endif

    always #5 PCLK = ~PCLK;

    spi_shifter_if bus ();

    assign SPIIn = loopSel ? SPIOut : spiInDrv;

    spi_shifter dut (
        .PCLK            (PCLK),
        .PRESETn         (PRESETn),
        .TransmitStart   (TransmitStart),
        .EndOfFrameDelay (EndOfFrameDelay),
        .ShiftEdge       (ShiftEdge),
        .SampleEdge      (SampleEdge),
        .Transmitting    (Transmitting),
        .FrameLength     (FrameLength),
        .Endian          (Endian),
        .SPIIn           (SPIIn),
`ifdef SPI_LOOPBACK_EN
        .Loopback        (Loopback),
`endif
        .SPIOut          (SPIOut),
        .fifoBus         (bus.master)
    );

    int         compared   = 0;
    int         mismatched = 0;
    int         dropCnt    = 0;
    logic [7:0] expQ[$];

    typedef struct {
        logic       endian;
        logic [3:0] frameLength;
        logic [7:0] txData;
        logic       useLoop;
        logic       full;
        int         nBits;
        logic [7:0] inSeq;   // serial input, first bit at [7]
        logic [7:0] expOut;  // expected SPIOut, first bit at [7]
        logic [7:0] expRx;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Scoreboard consumer: every RX push must match the oldest expected frame.
    always @(negedge PCLK) begin
        logic [7:0] e;
        if (PRESETn === 1'b1) begin
            if (bus.RxFIFOWrite === 1'b1) begin
                compared++;
                if (expQ.size() == 0) begin
                    mismatched++;
                    $display("FAIL rx_push: got unexpected push data %0h expected none", bus.RxData);
                end else begin
                    e = expQ.pop_front();
                    $display("rx push data=%0h expected=%0h", bus.RxData, e);
                    if (bus.RxData !== e) begin
                        mismatched++;
                        $display("FAIL rx_data: got %0h expected %0h", bus.RxData, e);
                    end
                end
            end
            if (bus.RxDropped === 1'b1) dropCnt++;
        end
    end

    task automatic startFrame(input logic [7:0] d, input logic endian, input logic [3:0] len);
        bus.TxData    = d;
        Endian        = endian;
        FrameLength   = len;
        TransmitStart = 1'b1;
        @(negedge PCLK);
        check("txfifo_read_on_start", bus.TxFIFORead, 1);
        tick();
        TransmitStart = 1'b0;
    endtask

    task automatic runBits(input int n, input logic [7:0] inSeq, input logic [7:0] expOut,
                           input logic useLoop, input logic pushExp, input logic [7:0] expRx);
        loopSel = useLoop;
        for (int i = 0; i < n; i++) begin
            spiInDrv = inSeq[7-i];
            if (i == n - 1 && pushExp) expQ.push_back(expRx);
            SampleEdge = 1'b1;
            @(negedge PCLK);
            check($sformatf("spiout_bit%0d", i), SPIOut, expOut[7-i]);
            tick();
            SampleEdge = 1'b0;
            ShiftEdge  = 1'b1;
            tick();
            ShiftEdge  = 1'b0;
        end
        tick();
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        vecs[0] = '{MSB_FIRST, 4'd8,  8'hA5, 1'b1, 1'b0, 8, 8'h00,        8'hA5,        8'hA5};
        vecs[1] = '{LSB_FIRST, 4'd4,  8'h0B, 1'b0, 1'b0, 4, 8'b1000_0000, 8'b1101_0000, 8'h01};
        vecs[2] = '{MSB_FIRST, 4'd4,  8'h0B, 1'b0, 1'b0, 4, 8'b1011_0000, 8'b1011_0000, 8'h0B};
        vecs[3] = '{MSB_FIRST, 4'd0,  8'h3C, 1'b0, 1'b0, 8, 8'b0110_1001, 8'b0011_1100, 8'h69};
        vecs[4] = '{LSB_FIRST, 4'd12, 8'h81, 1'b1, 1'b0, 8, 8'h00,        8'b1000_0001, 8'h81};
        vecs[5] = '{MSB_FIRST, 4'd8,  8'h55, 1'b1, 1'b1, 8, 8'h00,        8'h55,        8'h55};
        vecs[6] = '{MSB_FIRST, 4'd5,  8'h13, 1'b0, 1'b0, 5, 8'b1110_0000, 8'b1001_1000, 8'h1C};
        vecs[7] = '{LSB_FIRST, 4'd3,  8'h06, 1'b0, 1'b0, 3, 8'b1100_0000, 8'b0110_0000, 8'h03};

        PRESETn = 1'b0;
        TransmitStart = 0; EndOfFrameDelay = 0; ShiftEdge = 0; SampleEdge = 0;
        Transmitting = 1; FrameLength = 4'd8; Endian = 0;
        loopSel = 0; spiInDrv = 0;
        bus.TxData = 8'h00; bus.txFIFOReadEmpty = 1'b1; bus.rxFIFOWriteFull = 1'b0;
`ifdef SPI_LOOPBACK_EN
        Loopback = 1'b0;
`endif
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        check("reset_spiout", SPIOut, 0);
        check("reset_rxwrite", bus.RxFIFOWrite, 0);
        check("reset_rxdata", bus.RxData, 0);
        check("reset_rxdropped", bus.RxDropped, 0);
        check("reset_txread", bus.TxFIFORead, 0);
        tick();
        PRESETn = 1'b1;
        tick();

        // Table-driven single frames.
        for (int k = 0; k < 8; k++) begin
            bus.rxFIFOWriteFull = vecs[k].full;
            d0 = dropCnt;
            $display("vector %0d: tx=%0h len=%0d endian=%0d full=%0d", k, vecs[k].txData,
                     vecs[k].frameLength, vecs[k].endian, vecs[k].full);
            startFrame(vecs[k].txData, vecs[k].endian, vecs[k].frameLength);
            runBits(vecs[k].nBits, vecs[k].inSeq, vecs[k].expOut, vecs[k].useLoop,
                    !vecs[k].full, vecs[k].expRx);
            check($sformatf("drop_count_vec%0d", k), dropCnt - d0, vecs[k].full ? 1 : 0);
            if (!vecs[k].full) check($sformatf("rxdata_held_vec%0d", k), bus.RxData, vecs[k].expRx);
            bus.rxFIFOWriteFull = 1'b0;
        end

        // Two queued bytes: load on TransmitStart then on EndOfFrameDelay.
        bus.txFIFOReadEmpty = 1'b0;
        @(negedge PCLK);
        check("txread_idle", bus.TxFIFORead, 0);
        tick();
        startFrame(8'h12, MSB_FIRST, 4'd8);
        runBits(8, 8'h00, 8'h12, 1'b1, 1'b1, 8'h12);
        bus.TxData = 8'h34;
        EndOfFrameDelay = 1'b1;
        @(negedge PCLK);
        check("txread_on_eof", bus.TxFIFORead, 1);
        tick();
        EndOfFrameDelay = 1'b0;
        runBits(8, 8'h00, 8'h34, 1'b1, 1'b1, 8'h34);
        bus.txFIFOReadEmpty = 1'b1;
        EndOfFrameDelay = 1'b1;
        @(negedge PCLK);
        check("txread_eof_empty", bus.TxFIFORead, 0);
        tick();
        EndOfFrameDelay = 1'b0;

        // Restart after 3 samples, with a SampleEdge on the restart cycle.
        startFrame(8'hF0, MSB_FIRST, 4'd8);
        runBits(3, 8'h00, 8'b1110_0000, 1'b1, 1'b0, 8'h00);
        startFrame(8'h5A, MSB_FIRST, 4'd8);
        runBits(8, 8'h00, 8'h5A, 1'b1, 1'b1, 8'h5A);
        SampleEdge = 1'b1;
        startFrame(8'hC6, MSB_FIRST, 4'd8);
        SampleEdge = 1'b0;
        runBits(8, 8'h00, 8'hC6, 1'b1, 1'b1, 8'hC6);

        // Strobes ignored while not transmitting.
        Transmitting = 1'b0;
        startFrame(8'hA5, MSB_FIRST, 4'd8);
        loopSel = 1'b1; ShiftEdge = 1'b1; SampleEdge = 1'b1;
        tick();
        ShiftEdge = 1'b0; SampleEdge = 1'b0;
        @(negedge PCLK);
        check("spiout_hold_idle", SPIOut, 1);
        tick();
        Transmitting = 1'b1;
        runBits(8, 8'h00, 8'hA5, 1'b1, 1'b1, 8'hA5);

        // Asynchronous reset mid-frame.
        startFrame(8'hFF, MSB_FIRST, 4'd8);
        runBits(3, 8'h00, 8'hE0, 1'b1, 1'b0, 8'h00);
        #2;
        PRESETn = 1'b0;
        #1;
        check("areset_spiout", SPIOut, 0);
        check("areset_rxdata", bus.RxData, 0);
        check("areset_rxwrite", bus.RxFIFOWrite, 0);
        check("areset_rxdropped", bus.RxDropped, 0);
        check("areset_txread", bus.TxFIFORead, 0);
        tick();
        PRESETn = 1'b1;
        tick();
        startFrame(8'h3C, MSB_FIRST, 4'd8);
        runBits(8, 8'h00, 8'h3C, 1'b1, 1'b1, 8'h3C);

`ifdef SPI_LOOPBACK_EN
        Loopback = 1'b1;
        startFrame(8'hC3, MSB_FIRST, 4'd8);
        runBits(8, 8'h00, 8'hC3, 1'b0, 1'b1, 8'hC3);
        Loopback = 1'b0;
        startFrame(8'hC3, MSB_FIRST, 4'd8);
        runBits(8, 8'h00, 8'hC3, 1'b0, 1'b1, 8'h00);
`endif

        check("scoreboard_drained", expQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
